// File: rtl/ram_32x8_pkg.sv
// Shared memory geometry for the simulated computer: bus widths and the
// word/address types that the CPU datapath also uses.
package ram_32x8_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ram_32x8.sv
// Single-port 32 x 8 program/data memory: synchronous write and clear,
// combinational read with no write-data bypass.
module ram_32x8
    import ram_32x8_pkg::*;
#(
    parameter int unsigned DATA_W = ram_32x8_pkg::DATA_W,
    parameter int unsigned ADDR_W = ram_32x8_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);

    localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] mem_d [MEM_DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wen_i) begin
            mem_d[addr_i] = din_i;
        end
    end

    // Reset takes priority over a write presented in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dout_o = mem_q[addr_i];

endmodule

// File: tb/tb_ram_32x8.sv
// Self-checking bench for ram_32x8: directed scenarios plus a randomized run
// compared against a plain array model of the memory.
module tb_ram_32x8;

    logic       clk;
    logic       rst;
    logic       wen;
    logic [4:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    logic [7:0] model [32];
    int unsigned errors;
    int unsigned checks;

    ram_32x8 #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wen_i (wen),
        .addr_i(addr),
        .din_i (din),
        .dout_o(dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, applying the memory rules to the model.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 8'h00;
        end else if (wen) begin
            model[addr] = din;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wen = 1'b0; addr = '0; din = '0;
        step();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            addr = 5'(a);
            #1;
            checks++;
            if (dout !== 8'h00) begin
                errors++;
                $display("FAIL reset_sweep addr=%0d got=%h exp=00", a, dout);
            end
        end
    endtask

    task automatic test_write_basic();
        addr = 5'd1; din = 8'h07; wen = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL rdw_before_edge got=%h exp=00", dout);
        end
        step();
        wen = 1'b0;
        checks++;
        if (dout !== 8'h07) begin
            errors++;
            $display("FAIL write_addr1 got=%h exp=07", dout);
        end
        addr = 5'd2;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL untouched_addr2 got=%h exp=00", dout);
        end
    endtask

    task automatic test_write_disable();
        addr = 5'd2; din = 8'h05; wen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (dout !== 8'h00) begin
                errors++;
                $display("FAIL wen_low_hold edge=%0d got=%h exp=00", k, dout);
            end
        end
        wen = 1'b1;
        step();
        wen = 1'b0;
        checks++;
        if (dout !== 8'h05) begin
            errors++;
            $display("FAIL write_addr2 got=%h exp=05", dout);
        end
    endtask

    task automatic test_addr_change();
        logic [7:0] exp_seq [3];
        logic [4:0] addr_seq [3];
        exp_seq  = '{8'h05, 8'h07, 8'h05};
        addr_seq = '{5'd2, 5'd1, 5'd2};
        wen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            addr = addr_seq[k];
            #1;
            checks++;
            if (dout !== exp_seq[k]) begin
                errors++;
                $display("FAIL comb_read step=%0d addr=%0d got=%h exp=%h",
                         k, addr, dout, exp_seq[k]);
            end
        end
    endtask

    task automatic test_fill_and_reset_priority();
        for (int a = 0; a < 32; a++) begin
            addr = 5'(a); din = 8'(a) ^ 8'hA5; wen = 1'b1;
            step();
        end
        wen = 1'b0;
        for (int a = 0; a < 32; a++) begin
            addr = 5'(a);
            #1;
            checks++;
            if (dout !== (8'(a) ^ 8'hA5)) begin
                errors++;
                $display("FAIL fill_readback addr=%0d got=%h exp=%h", a, dout, 8'(a) ^ 8'hA5);
            end
        end
        addr = 5'd9; rst = 1'b1; wen = 1'b1; din = 8'hFF;
        step();
        rst = 1'b0; wen = 1'b0;
        for (int a = 0; a < 32; a++) begin
            addr = 5'(a);
            #1;
            checks++;
            if (dout !== 8'h00) begin
                errors++;
                $display("FAIL reset_over_write addr=%0d got=%h exp=00", a, dout);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        for (int k = 0; k < 6; k++) begin
            addr = 5'($urandom_range(0, 31)); din = 8'($urandom); wen = 1'b1;
            step();
        end
        wen = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            addr = 5'(a);
            #1;
            checks++;
            if (dout !== 8'h00) begin
                errors++;
                $display("FAIL mid_reset addr=%0d got=%h exp=00", a, dout);
            end
        end
        addr = 5'd31; din = 8'h3C; wen = 1'b1;
        step();
        wen = 1'b0;
        checks++;
        if (dout !== 8'h3C) begin
            errors++;
            $display("FAIL post_reset_write addr=31 got=%h exp=3c", dout);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst  = ($urandom_range(0, 49) == 0);
            wen  = ($urandom_range(0, 1) == 1);
            addr = 5'($urandom_range(0, 31));
            din  = 8'($urandom);
            #1;
            checks++;
            if (dout !== model[addr]) begin
                errors++;
                $display("FAIL random_pre iter=%0d addr=%0d got=%h exp=%h", k, addr, dout, model[addr]);
            end
            step();
            checks++;
            if (dout !== model[addr]) begin
                errors++;
                $display("FAIL random_post iter=%0d addr=%0d got=%h exp=%h", k, addr, dout, model[addr]);
            end
        end
        rst = 1'b0; wen = 1'b0;
        for (int a = 0; a < 32; a++) begin
            addr = 5'(a);
            #1;
            checks++;
            if (dout !== model[a]) begin
                errors++;
                $display("FAIL random_final addr=%0d got=%h exp=%h", a, dout, model[a]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        rst = 1'b0; wen = 1'b0; addr = '0; din = '0;
        @(negedge clk);
        test_reset();
        test_write_basic();
        test_write_disable();
        test_addr_change();
        test_fill_and_reset_priority();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
